// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command-side handshake and status bundle for the PS/2 host transmitter
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, tx_done, tx_error
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, tx_done, tx_error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibits the bus, issues request-to-send, then shifts one odd-parity byte out on device clock falls.
module ps2_host_tx #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_US = 15_000,
   parameter int unsigned FRAME_US   = 2_000
) (
   input  logic         clk,
   input  logic         rst_n,
   ps2_host_tx_if.slave host,
   input  logic         ps2_clk_i,
   input  logic         ps2_data_i,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   localparam longint unsigned INHIBIT_CYC = 64'(INHIBIT_US) * 64'(CLK_HZ) / 64'd1_000_000;
   localparam longint unsigned TIMEOUT_CYC = 64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000;
   localparam longint unsigned FRAME_CYC   = 64'(FRAME_US)   * 64'(CLK_HZ) / 64'd1_000_000;
   localparam longint unsigned MAX_CYC =
      (TIMEOUT_CYC > FRAME_CYC) ? ((TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC)
                                : ((FRAME_CYC   > INHIBIT_CYC) ? FRAME_CYC   : INHIBIT_CYC);
   localparam int TW = $clog2(MAX_CYC + 64'd1);

   localparam logic [TW-1:0] INHIBIT_END = TW'(INHIBIT_CYC - 64'd1);
   localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYC - 64'd1);
   localparam logic [TW-1:0] FRAME_END   = TW'(FRAME_CYC - 64'd1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR
   } state_t;

   state_t        state, state_next;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_prev;
   logic          sync_clk, sync_data, fall;
   logic [TW-1:0] timer;
   logic          timer_clr;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic          drive_low;
   logic          frame_exp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_i};
         data_sync <= {data_sync[0], ps2_data_i};
         clk_prev  <= clk_sync[1];
      end
   end

   assign sync_clk  = clk_sync[1];
   assign sync_data = data_sync[1];
   assign fall      = clk_prev & ~sync_clk;
   assign frame_exp = (timer == FRAME_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next    = state;
      host.tx_ready = 1'b0;
      host.busy     = 1'b1;
      host.tx_done  = 1'b0;
      host.tx_error = 1'b0;
      ps2_clk_oe    = 1'b0;
      case (state)
         IDLE: begin
            host.tx_ready = 1'b1;
            host.busy     = 1'b0;
            if (host.tx_valid) state_next = INHIBIT;
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (timer == INHIBIT_END) state_next = REQ;
         end
         REQ: begin
            ps2_clk_oe = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            // Before the first fall the timer measures the device response, afterwards the whole frame.
            if (bit_cnt == 4'd0 && timer == TIMEOUT_END)      state_next = ERR;
            else if (bit_cnt != 4'd0 && frame_exp)            state_next = ERR;
            else if (fall && bit_cnt == 4'd9)                 state_next = ACK;
         end
         ACK: begin
            if (frame_exp)  state_next = ERR;
            else if (fall)  state_next = sync_data ? ERR : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (frame_exp)                   state_next = ERR;
            else if (sync_clk && sync_data)  state_next = DONE;
         end
         DONE: begin
            host.tx_done = 1'b1;
            state_next   = IDLE;
         end
         ERR: begin
            host.tx_error = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign timer_clr = (state == IDLE)
                    | (state == INHIBIT && state_next == REQ)
                    | (state == SEND && fall && bit_cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            timer <= '0;
      else if (timer_clr)    timer <= '0;
      else if (timer != '1)  timer <= timer + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (state == IDLE) begin
         bit_cnt <= '0;
         if (host.tx_valid) shreg <= {1'b1, ~^host.tx_data, host.tx_data};
      end else if (state == SEND && fall) begin
         bit_cnt <= bit_cnt + 4'd1;
         shreg   <= {1'b1, shreg[9:1]};
      end
   end

   // Data is driven low for the start bit from REQ onward and then follows each shifted bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       drive_low <= 1'b0;
      else if (state_next == ERR || state_next == IDLE) drive_low <= 1'b0;
      else if (state == INHIBIT)                        drive_low <= (state_next == REQ);
      else if (state == SEND && fall)                   drive_low <= ~shreg[0];
   end

   assign ps2_data_oe = drive_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench with an open-drain PS/2 device model
module tb_ps2_host_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic ps2_clk_oe, ps2_data_oe;
   logic ps2_clk_line, ps2_data_line;

   assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx_if bus();

   ps2_host_tx #(.CLK_HZ(1_000_000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .host        (bus),
      .ps2_clk_i   (ps2_clk_line),
      .ps2_data_i  (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   always @(negedge clk) begin
      if (bus.tx_done)  done_cnt++;
      if (bus.tx_error) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_rts(output int inh, output int req, output bit ok);
      inh = 0; req = 0; ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (ps2_clk_oe && !ps2_data_oe)      inh++;
         else if (ps2_clk_oe && ps2_data_oe)  req++;
         else if (req > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // 40-cycle device clock; bits sampled just before each rise; optional ack before fall 11.
   task automatic clock_frame(input bit ack, input int abort_at, output logic [9:0] bits);
      bits = '0;
      for (int f = 1; f <= 11; f++) begin
         tick(10);
         if (f == 11 && ack) dev_data = 1'b0;
         tick(10);
         dev_clk = 1'b0;
         if (f == abort_at) return;
         tick(20);
         if (f <= 10) bits[f-1] = ps2_data_line;
         dev_clk = 1'b1;
      end
      tick(5);
      dev_data = 1'b1;
   endtask

   task automatic do_frame(input logic [7:0] b, input bit ack, input bit poke,
                           output logic [9:0] bits, output int inh, output int req);
      bit ok;
      send(b);
      if (poke) begin
         bus.tx_data  = 8'h55;
         bus.tx_valid = 1'b1;
         tick(3);
         bus.tx_valid = 1'b0;
      end
      wait_rts(inh, req, ok);
      check("rts_seen", 32'(ok), 32'd1);
      clock_frame(ack, 0, bits);
      tick(50);
   endtask

   logic [9:0] bits;
   int inh, req, d0, e0, n;
   bit ok;

   initial begin
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;

      tick(3);
      check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_busy",     32'(bus.busy),     32'd0);
      check("rst_clk_oe",   32'(ps2_clk_oe),   32'd0);
      check("rst_data_oe",  32'(ps2_data_oe),  32'd0);
      check("rst_tx_done",  32'(bus.tx_done),  32'd0);
      check("rst_tx_error", 32'(bus.tx_error), 32'd0);
      rst_n = 1'b1;
      tick(3);

      // 0xED: full frame with inhibit timing
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      wait_rts(inh, req, ok);
      check("ed_rts_seen",   32'(ok),          32'd1);
      check("ed_inhibit",    32'(inh),         32'd100);
      check("ed_req",        32'(req),         32'd1);
      check("ed_start_bit",  32'(ps2_data_oe), 32'd1);
      check("ed_busy",       32'(bus.busy),    32'd1);
      clock_frame(1'b1, 0, bits);
      tick(50);
      check("ed_byte",       32'(bits[7:0]),   32'hED);
      check("ed_parity",     32'(bits[8]),     32'd1);
      check("ed_stop",       32'(bits[9]),     32'd1);
      check("ed_done",       32'(done_cnt - d0), 32'd1);
      check("ed_no_err",     32'(err_cnt - e0),  32'd0);

      // 0x01 with a 0x55 request during busy that must be dropped
      d0 = done_cnt;
      do_frame(8'h01, 1'b1, 1'b1, bits, inh, req);
      check("x01_byte",      32'(bits[7:0]),   32'h01);
      check("x01_parity",    32'(bits[8]),     32'd0);
      check("x01_done",      32'(done_cnt - d0), 32'd1);
      check("x55_not_queued_busy",   32'(bus.busy),   32'd0);
      check("x55_not_queued_clk_oe", 32'(ps2_clk_oe), 32'd0);

      d0 = done_cnt;
      do_frame(8'hFF, 1'b1, 1'b0, bits, inh, req);
      check("xff_byte",      32'(bits[7:0]),   32'hFF);
      check("xff_parity",    32'(bits[8]),     32'd1);
      check("xff_done",      32'(done_cnt - d0), 32'd1);

      d0 = done_cnt;
      do_frame(8'h55, 1'b1, 1'b0, bits, inh, req);
      check("x55_byte",      32'(bits[7:0]),   32'h55);
      check("x55_parity",    32'(bits[8]),     32'd1);
      check("x55_done",      32'(done_cnt - d0), 32'd1);

      // device never clocks: timeout counted from the REQ cycle
      d0 = done_cnt; e0 = err_cnt;
      send(8'h12);
      wait_rts(inh, req, ok);
      check("tmo_rts_seen",  32'(ok), 32'd1);
      n = 1;
      while (!bus.tx_error && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("tmo_cycles",    32'(n),           32'd15000);
      check("tmo_clk_oe",    32'(ps2_clk_oe),  32'd0);
      check("tmo_data_oe",   32'(ps2_data_oe), 32'd0);
      tick(1);
      check("tmo_tx_ready",  32'(bus.tx_ready), 32'd1);
      check("tmo_err",       32'(err_cnt - e0),  32'd1);
      check("tmo_no_done",   32'(done_cnt - d0), 32'd0);

      // no ack at edge 11
      d0 = done_cnt; e0 = err_cnt;
      do_frame(8'h3C, 1'b0, 1'b0, bits, inh, req);
      check("nack_byte",     32'(bits[7:0]),   32'h3C);
      check("nack_err",      32'(err_cnt - e0),  32'd1);
      check("nack_no_done",  32'(done_cnt - d0), 32'd0);

      // reset after fall 5 of 0xED (bit4 = 0, so data is being driven low)
      send(8'hED);
      wait_rts(inh, req, ok);
      check("rst_rts_seen",  32'(ok), 32'd1);
      clock_frame(1'b1, 5, bits);
      tick(8);
      check("mid_data_oe",   32'(ps2_data_oe), 32'd1);
      check("mid_clk_oe",    32'(ps2_clk_oe),  32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_clk_oe",   32'(ps2_clk_oe),  32'd0);
      check("arst_data_oe",  32'(ps2_data_oe), 32'd0);
      check("arst_busy",     32'(bus.busy),    32'd0);
      check("arst_tx_ready", 32'(bus.tx_ready), 32'd1);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);

      d0 = done_cnt;
      do_frame(8'hF4, 1'b1, 1'b0, bits, inh, req);
      check("xf4_byte",      32'(bits[7:0]),   32'hF4);
      check("xf4_parity",    32'(bits[8]),     32'd0);
      check("xf4_done",      32'(done_cnt - d0), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
